l1_acc_unit: RTL and testbench

//  Consumes streamed activation/weight pairs and accumulates the AdderNet

---
 rtl/l1_acc_unit.sv | 94 +++++++++
 tb/tb_l1_acc_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/l1_acc_unit.sv
// Accumulates -sum|X-W| over KLEN streamed pairs and emits one signed result per window.
// Latency: o_valid rises one cycle after the final term is accepted; KLEN+1 cycles per window.
// Backpressure: result held in OUT until i_ready; o_ready is low in OUT and during reset.
module l1_acc_unit #(
    parameter int NBIT = 8,
    parameter int KLEN = 9,
    parameter int ACCW = NBIT + 1 + $clog2(KLEN)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [NBIT-1:0]            i_X,
    input  logic [NBIT-1:0]            i_W,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [ACCW-1:0]            o_Y,
    output logic [$clog2(KLEN+1)-1:0]  o_cnt
);

    localparam int CNTW = $clog2(KLEN + 1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ACCW-1:0]    acc_q;
    logic signed [NBIT:0] diff;
    logic [NBIT:0]      abs_d;
    logic [ACCW-1:0]    acc_sum;
    logic               in_fire;
    logic               last_term;

    // One extra bit makes the difference exact; its magnitude then fits NBIT+1 unsigned bits.
    assign diff = $signed({i_X[NBIT-1], i_X}) - $signed({i_W[NBIT-1], i_W});

    always_comb begin
        abs_d = diff;
        if (diff[NBIT]) begin
            abs_d = -diff;
        end
    end

    assign acc_sum   = acc_q + ACCW'(abs_d);
    assign last_term = (o_cnt == CNTW'(KLEN - 1));
    assign in_fire   = i_valid & o_ready;

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            ST_ACC: begin
                o_ready = ~i_rst;
                if (i_valid && !i_rst && last_term) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
            o_cnt <= '0;
            o_Y   <= '0;
        end else if (in_fire) begin
            if (last_term) begin
                o_Y   <= -acc_sum;
                acc_q <= '0;
                o_cnt <= '0;
            end else begin
                acc_q <= acc_sum;
                o_cnt <= o_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_l1_acc_unit.sv
// Directed bench for l1_acc_unit (NBIT=8, KLEN=9): hand-computed window results,
// backpressure hold, gapped input, and mid-window reset.
module tb_l1_acc_unit;

    localparam int NBIT = 8;
    localparam int KLEN = 9;
    localparam int ACCW = NBIT + 1 + $clog2(KLEN);
    localparam int CNTW = $clog2(KLEN + 1);

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic [NBIT-1:0]   i_X;
    logic [NBIT-1:0]   i_W;
    logic              o_valid;
    logic              i_ready;
    logic [ACCW-1:0]   o_Y;
    logic [CNTW-1:0]   o_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    l1_acc_unit #(.NBIT(NBIT), .KLEN(KLEN)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_X     (i_X),
        .i_W     (i_W),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_Y     (o_Y),
        .o_cnt   (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int y_val();
        return int'($signed(o_Y));
    endfunction

    // Drives n pairs; each pair is presented at a negedge and accepted at the following posedge.
    task automatic feed(input int x, input int w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int t;
            if (i > 0) repeat (gap) @(negedge clk);
            @(negedge clk);
            t = 0;
            while (!o_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("ready_timeout", 0, 1);
            i_valid = 1'b1;
            i_X     = NBIT'(x);
            i_W     = NBIT'(w);
            @(posedge clk);
            #1 i_valid = 1'b0;
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_X     = '0;
        i_W     = '0;
        i_ready = 1'b1;

        // Reset state
        #12;
        check("rst_ready", int'(o_ready), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_cnt",   int'(o_cnt),   0);
        check("rst_y",     y_val(),       0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(o_ready), 1);

        // 1: 9 x |5-2| = 27, presented for a single cycle
        feed(5, 2, 9, 0);
        @(negedge clk);
        check("t1_valid", int'(o_valid), 1);
        check("t1_y",     y_val(),       -27);
        check("t1_ready", int'(o_ready), 0);
        check("t1_cnt",   int'(o_cnt),   0);
        @(negedge clk);
        check("t1_valid_drop", int'(o_valid), 0);
        check("t1_ready_back", int'(o_ready), 1);

        // 2: extreme operands, 9 x 255 = 2295
        feed(-128, 127, 9, 0);
        @(negedge clk);
        check("t2_valid", int'(o_valid), 1);
        check("t2_y",     y_val(),       -2295);
        check("t2_raw",   int'(o_Y),     32'h1709);

        // 3: zero result still flagged valid
        feed(-7, -7, 9, 0);
        @(negedge clk);
        check("t3_valid", int'(o_valid), 1);
        check("t3_y",     y_val(),       0);

        // 4: backpressure hold; stray input during the stall must be ignored
        @(negedge clk);
        i_ready = 1'b0;
        feed(10, 4, 9, 0);
        i_valid = 1'b1;
        i_X     = 8'd100;
        i_W     = 8'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_hold_valid", int'(o_valid), 1);
            check("t4_hold_y",     y_val(),       -54);
            check("t4_hold_ready", int'(o_ready), 0);
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        check("t4_release_valid", int'(o_valid), 0);
        check("t4_release_cnt",   int'(o_cnt),   0);

        // 5: one-cycle gaps; o_cnt counts only accepted terms
        for (int i = 0; i < KLEN; i++) begin
            @(negedge clk);
            check("t5_cnt_idle", int'(o_cnt), i);
            @(negedge clk);
            check("t5_cnt", int'(o_cnt), i);
            i_valid = 1'b1;
            i_X     = 8'd3;
            i_W     = 8'hFF;
            @(posedge clk);
            #1 i_valid = 1'b0;
        end
        @(negedge clk);
        check("t5_valid", int'(o_valid), 1);
        check("t5_y",     y_val(),       -36);

        // 6: reset mid-window discards the partial sum
        @(negedge clk);
        feed(50, 0, 4, 0);
        @(negedge clk);
        check("t6_cnt_before", int'(o_cnt), 4);
        rst = 1'b1;
        #1;
        check("t6_rst_cnt",   int'(o_cnt),   0);
        check("t6_rst_ready", int'(o_ready), 0);
        check("t6_rst_valid", int'(o_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        feed(1, 0, 9, 0);
        @(negedge clk);
        check("t6_valid", int'(o_valid), 1);
        check("t6_y",     y_val(),       -9);
        @(negedge clk);
        check("t6_done", int'(o_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
